logic_axi4_stream_mux_arbiter: RTL and testbench
================================================

LOGIC_AXI4_STREAM_MUX_ARBITER -- requirements
Module: logic_axi4_stream_mux_arbiter

Interface
REQ-001 Parameter INPUTS, default 4: number of requesting AXI4-Stream inputs, legal range 1..64.
REQ-002 Parameter USE_TLAST, default 1: 1 = hold the grant for a whole packet; 0 = re-arbitrate after every beat.
REQ-003 Parameter SELECT_WIDTH, default (INPUTS > 1) ? $clog2(INPUTS) : 1: width of the select output.
REQ-004 aclk  input  1  clock; all state updates on the rising edge.
REQ-005 areset_n  input  1  reset; asynchronous, active-low.
REQ-006 rx_tvalid  input  INPUTS  per-input tvalid, used as the request.
REQ-007 rx_tlast  input  INPUTS  per-input tlast.
REQ-008 rx_tready  output  INPUTS  per-input tready; asserted only on the granted input.
REQ-009 tx_tvalid  output  1  tvalid towards the downstream sink.
REQ-010 tx_tlast  output  1  tlast towards the downstream sink.
REQ-011 tx_tready  input  1  tready from the downstream sink.
REQ-012 grant  output  INPUTS  one-hot grant; all zero when idle.
REQ-013 select  output  SELECT_WIDTH  binary index of the granted input; drives the external data mux.
REQ-014 busy  output  1  high while in LOCKED.

Function
REQ-015 The block SHALL implement two states, IDLE and LOCKED, held in registers.
REQ-016 In IDLE:
- grant = 0, tx_tvalid = 0, rx_tready = 0.
- If any rx_tvalid bit is high, the winner is the first set bit found scanning upward from pointer, wrapping modulo INPUTS.
- On the next edge: state = LOCKED, grant = onehot(winner), select = winner.
REQ-017 Arbitration latency SHALL be exactly 1 cycle from request seen in IDLE to grant asserted; grant, select and state are registered outputs.
REQ-018 In LOCKED, for select = s:
- tx_tvalid = rx_tvalid[s].
- rx_tready[s] = tx_tready.
- rx_tready[j] = 0 for all j != s.
- These paths are combinational.
REQ-019 tx_tlast SHALL equal rx_tlast[s] when USE_TLAST=1, and SHALL be constant 1 when USE_TLAST=0.
REQ-020 The transfer beat is defined as tx_tvalid && tx_tready. Release occurs on a beat with rx_tlast[s]=1 (USE_TLAST=1) or on any beat (USE_TLAST=0).
REQ-021 On release, at the same edge: state = IDLE, grant = 0, pointer = (s+1) mod INPUTS; select SHALL hold its value.
REQ-022 Between packets there SHALL be exactly one idle (no-grant) cycle; the maximum rate is one packet every (length+1) cycles.
REQ-023 While LOCKED, new requests on other inputs SHALL be ignored; deassertion of rx_tvalid[s] mid-packet SHALL NOT release the lock.
REQ-024 While LOCKED with tx_tready=0, all outputs SHALL hold and no release SHALL occur.
REQ-025 With INPUTS=1, pointer and select SHALL remain 0.
REQ-026 Requests arriving simultaneously SHALL be resolved by round-robin only. Starvation-free: a continuously requesting input SHALL be granted within INPUTS-1 other packets.
REQ-027 busy SHALL be 1 exactly when state = LOCKED.

Reset
REQ-028 While areset_n=0, the block SHALL asynchronously force:
- state = IDLE, pointer = 0, select = 0, grant = 0, busy = 0.
- As a result, rx_tready = 0 and tx_tvalid = 0.
REQ-029 Reset asserted mid-packet SHALL abort the lock immediately. After deassertion, arbitration SHALL restart from pointer 0.
REQ-030 Release from reset SHALL take effect on the first rising aclk edge after areset_n rises; no output SHALL change earlier.

Verification (INPUTS=4, USE_TLAST=1 unless noted)
REQ-031 After reset, rx_tvalid=4'b1111 with each input sending 2-beat packets and tx_tready=1 -> grant sequence 0001, 0010, 0100, 1000, 0001 with one idle cycle between each grant.
REQ-032 rx_tvalid=4'b0100 rising at cycle 0 -> grant=4'b0100 and select=2 at cycle 1; a 3-beat packet -> release after beat 3, then pointer=3.
REQ-033 While input 1 is locked, toggle rx_tvalid[1] low for 2 cycles and raise rx_tvalid[0] -> grant stays 4'b0010; rx_tready[0]=0 throughout; lock releases only on the tlast beat.
REQ-034 While locked with tx_tready=0 for 5 cycles and rx_tlast high -> no release, state and grant stable; tx_tready=1 -> release on that edge.
REQ-035 With USE_TLAST=0 and rx_tvalid=4'b0011 held -> grants alternate 0001, 0010 with one beat each; tx_tlast=1 on every beat.
REQ-036 areset_n pulsed low during beat 2 of a 4-beat packet on input 3 -> grant=0 and rx_tready=0 immediately; after release, with rx_tvalid=4'b1000, input 3 is granted again from pointer 0.

Source files
------------

// File: rtl/logic_axi4_stream_mux_arbiter.sv
// Round-robin arbiter for N AXI4-Stream sources onto one sink.
// The grant is held for a whole packet (or a single beat when tlast is ignored); select drives an external data mux.
module logic_axi4_stream_mux_arbiter #(
    parameter int INPUTS       = 4,
    parameter int USE_TLAST    = 1,
    parameter int SELECT_WIDTH = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [INPUTS-1:0]       rx_tvalid,
    input  logic [INPUTS-1:0]       rx_tlast,
    output logic [INPUTS-1:0]       rx_tready,
    output logic                    tx_tvalid,
    output logic                    tx_tlast,
    input  logic                    tx_tready,
    output logic [INPUTS-1:0]       grant,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    busy
);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_LOCKED = 1'b1;

    localparam logic [SELECT_WIDTH:0] INPUTS_W = (SELECT_WIDTH + 1)'(INPUTS);
    localparam logic [SELECT_WIDTH:0] ONE_W    = (SELECT_WIDTH + 1)'(1);

    logic [0:0]              state;
    logic [SELECT_WIDTH-1:0] pointer;

    logic [2*INPUTS-1:0]     req_dbl;
    logic [INPUTS-1:0]       req_rot;
    logic [SELECT_WIDTH:0]   offset;
    logic [SELECT_WIDTH:0]   win_sum;
    logic [SELECT_WIDTH-1:0] winner;
    logic [INPUTS-1:0]       winner_onehot;
    logic [SELECT_WIDTH:0]   sel_inc;
    logic [SELECT_WIDTH-1:0] next_pointer;
    logic                    release_lock;

    // Rotate requests so the pointer position sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        req_dbl = {rx_tvalid, rx_tvalid} >> pointer;
        req_rot = req_dbl[INPUTS-1:0];
        offset  = '0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = (SELECT_WIDTH + 1)'(i);
            end
        end
        win_sum = {1'b0, pointer} + offset;
        if (win_sum >= INPUTS_W) begin
            win_sum = win_sum - INPUTS_W;
        end
        winner        = win_sum[SELECT_WIDTH-1:0];
        winner_onehot = INPUTS'(1) << winner;
    end

    always_comb begin
        sel_inc      = {1'b0, select} + ONE_W;
        next_pointer = (sel_inc == INPUTS_W) ? '0 : sel_inc[SELECT_WIDTH-1:0];
    end

    assign busy         = (state == STATE_LOCKED);
    assign tx_tvalid    = busy && rx_tvalid[select];
    assign tx_tlast     = (USE_TLAST != 0) ? rx_tlast[select] : 1'b1;
    assign rx_tready    = grant & {INPUTS{tx_tready}};
    assign release_lock = tx_tvalid && tx_tready && tx_tlast;

    // Select deliberately keeps its value across release so the data mux stays stable in the idle gap.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= STATE_IDLE;
            pointer <= '0;
            select  <= '0;
            grant   <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (|rx_tvalid) begin
                        state  <= STATE_LOCKED;
                        grant  <= winner_onehot;
                        select <= winner;
                    end
                end
                STATE_LOCKED: begin
                    if (release_lock) begin
                        state   <= STATE_IDLE;
                        grant   <= '0;
                        pointer <= next_pointer;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_axi4_stream_mux_arbiter.sv
// Self-checking bench for logic_axi4_stream_mux_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin packet-level model (packet mode and per-beat mode instances).
module tb_logic_axi4_stream_mux_arbiter;

    logic       aclk;
    logic       areset_n;

    logic [3:0] rx_tvalid, rx_tlast, rx_tready, grant;
    logic       tx_tvalid, tx_tlast, tx_tready, busy;
    logic [1:0] select;

    logic [3:0] nl_rx_tvalid, nl_rx_tlast, nl_rx_tready, nl_grant;
    logic       nl_tx_tvalid, nl_tx_tlast, nl_tx_tready, nl_busy;
    logic [1:0] nl_select;

    int checks   = 0;
    int failures = 0;

    logic m_locked, n_locked;
    int   m_owner, m_ptr, m_select, n_owner, n_ptr;

    logic_axi4_stream_mux_arbiter #(.INPUTS(4), .USE_TLAST(1)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .grant(grant), .select(select), .busy(busy)
    );

    logic_axi4_stream_mux_arbiter #(.INPUTS(4), .USE_TLAST(0)) dut_nl (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(nl_rx_tvalid), .rx_tlast(nl_rx_tlast), .rx_tready(nl_rx_tready),
        .tx_tvalid(nl_tx_tvalid), .tx_tlast(nl_tx_tlast), .tx_tready(nl_tx_tready),
        .grant(nl_grant), .select(nl_select), .busy(nl_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    // Packet-level reference: who owns the sink, and where the next round-robin search starts.
    always @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            m_locked <= 1'b0; m_owner <= 0; m_ptr <= 0; m_select <= 0;
            n_locked <= 1'b0; n_owner <= 0; n_ptr <= 0;
        end else begin
            if (!m_locked) begin
                if (rx_tvalid != 4'b0) begin
                    m_locked <= 1'b1;
                    m_owner  <= rr_pick(rx_tvalid, m_ptr);
                    m_select <= rr_pick(rx_tvalid, m_ptr);
                end
            end else if (rx_tvalid[m_owner] && tx_tready && rx_tlast[m_owner]) begin
                m_locked <= 1'b0;
                m_ptr    <= (m_owner + 1) % 4;
            end
            if (!n_locked) begin
                if (nl_rx_tvalid != 4'b0) begin
                    n_locked <= 1'b1;
                    n_owner  <= rr_pick(nl_rx_tvalid, n_ptr);
                end
            end else if (nl_rx_tvalid[n_owner] && nl_tx_tready) begin
                n_locked <= 1'b0;
                n_ptr    <= (n_owner + 1) % 4;
            end
        end
    end

    task automatic clear_inputs();
        rx_tvalid = 4'b0; rx_tlast = 4'b0; tx_tready = 1'b0;
        nl_rx_tvalid = 4'b0; nl_rx_tlast = 4'b0; nl_tx_tready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge aclk);
        areset_n = 1'b0;
        @(negedge aclk);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        clear_inputs();
        rx_tvalid = 4'b1111; rx_tlast = 4'b1111; tx_tready = 1'b1;
        #3;
        repeat (2) @(posedge aclk);
        #3;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (select !== 2'd0) begin failures++; $display("[TB] FAIL reset_select got=%0d exp=0", select); end
        checks++; if (rx_tready !== 4'b0) begin failures++; $display("[TB] FAIL reset_rx_tready got=%b exp=0000", rx_tready); end
        checks++; if (tx_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_tvalid got=%b exp=0", tx_tvalid); end
        @(negedge aclk);
        areset_n = 1'b1;
        #2;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL reset_release_early got=%b exp=0000", grant); end
        @(posedge aclk);
        #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL reset_first_grant got=%b exp=0001", grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [13];
        exp_seq = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0100,
                    4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        do_reset();
        rx_tvalid = 4'b1111; tx_tready = 1'b1;
        #2;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL rr_idle_before got=%b exp=0000", grant); end
        @(posedge aclk); #1;
        for (int c = 0; c < 13; c++) begin
            rx_tlast = (c % 3 == 1) ? 4'b1111 : 4'b0000;
            #2;
            checks++;
            if (grant !== exp_seq[c]) begin
                failures++; $display("[TB] FAIL rr_grant cycle=%0d got=%b exp=%b", c, grant, exp_seq[c]);
            end
            checks++;
            if (busy !== (exp_seq[c] != 4'b0)) begin
                failures++; $display("[TB] FAIL rr_busy cycle=%0d got=%b exp=%b", c, busy, exp_seq[c] != 4'b0);
            end
            @(posedge aclk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_single_request();
        do_reset();
        rx_tvalid = 4'b0100; tx_tready = 1'b1;
        #2;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL single_cycle0 got=%b exp=0000", grant); end
        @(posedge aclk); #1;
        for (int b = 1; b <= 3; b++) begin
            rx_tlast = (b == 3) ? 4'b0100 : 4'b0000;
            #2;
            checks++; if (grant !== 4'b0100) begin failures++; $display("[TB] FAIL single_grant beat=%0d got=%b exp=0100", b, grant); end
            checks++; if (select !== 2'd2) begin failures++; $display("[TB] FAIL single_select beat=%0d got=%0d exp=2", b, select); end
            checks++; if (rx_tready !== 4'b0100) begin failures++; $display("[TB] FAIL single_ready beat=%0d got=%b exp=0100", b, rx_tready); end
            @(posedge aclk); #1;
        end
        rx_tlast = 4'b0;
        #2;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL single_release got=%b exp=0000", grant); end
        checks++; if (select !== 2'd2) begin failures++; $display("[TB] FAIL single_select_hold got=%0d exp=2", select); end
        rx_tvalid = 4'b1111;
        @(posedge aclk); #1;
        checks++; if (grant !== 4'b1000) begin failures++; $display("[TB] FAIL single_next_ptr got=%b exp=1000", grant); end
        clear_inputs();
    endtask

    task automatic test_lock_hold();
        do_reset();
        rx_tvalid = 4'b0010; tx_tready = 1'b1;
        @(posedge aclk); #1;
        #2;
        checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL hold_initial got=%b exp=0010", grant); end
        @(posedge aclk); #1;
        rx_tvalid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL hold_grant c=%0d got=%b exp=0010", c, grant); end
            checks++; if (rx_tready[0] !== 1'b0) begin failures++; $display("[TB] FAIL hold_ready0 c=%0d got=%b exp=0", c, rx_tready[0]); end
            checks++; if (tx_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL hold_tvalid c=%0d got=%b exp=0", c, tx_tvalid); end
            @(posedge aclk); #1;
        end
        rx_tvalid = 4'b0011;
        #2;
        checks++; if (rx_tready !== 4'b0010) begin failures++; $display("[TB] FAIL hold_ready_back got=%b exp=0010", rx_tready); end
        @(posedge aclk); #1;
        rx_tlast = 4'b0010;
        #2;
        checks++; if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL hold_last_beat got=%b exp=0010", grant); end
        @(posedge aclk); #1;
        rx_tlast = 4'b0;
        #2;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL hold_release got=%b exp=0000", grant); end
        @(posedge aclk); #1;
        checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL hold_wrap got=%b exp=0001", grant); end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        rx_tvalid = 4'b0001; rx_tlast = 4'b0001; tx_tready = 1'b0;
        @(posedge aclk); #1;
        for (int c = 0; c < 5; c++) begin
            #2;
            checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("[TB] FAIL bp_stall c=%0d grant=%b busy=%b exp=0001/1", c, grant, busy); end
            checks++; if (rx_tready !== 4'b0 || tx_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL bp_outputs c=%0d ready=%b tvalid=%b exp=0000/1", c, rx_tready, tx_tvalid); end
            @(posedge aclk); #1;
        end
        tx_tready = 1'b1;
        #2;
        checks++; if (rx_tready !== 4'b0001) begin failures++; $display("[TB] FAIL bp_ready got=%b exp=0001", rx_tready); end
        @(posedge aclk); #1;
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_release grant=%b busy=%b exp=0000/0", grant, busy); end
        clear_inputs();
    endtask

    task automatic test_no_tlast();
        logic [3:0] exp_g;
        do_reset();
        nl_rx_tvalid = 4'b0011; nl_tx_tready = 1'b1;
        @(posedge aclk); #1;
        for (int c = 0; c < 8; c++) begin
            exp_g = (c % 2 == 1) ? 4'b0000 : (((c / 2) % 2 == 0) ? 4'b0001 : 4'b0010);
            #2;
            checks++; if (nl_grant !== exp_g) begin failures++; $display("[TB] FAIL nl_grant c=%0d got=%b exp=%b", c, nl_grant, exp_g); end
            if (exp_g != 4'b0) begin
                checks++; if (nl_tx_tlast !== 1'b1 || nl_tx_tvalid !== 1'b1) begin failures++; $display("[TB] FAIL nl_beat c=%0d tlast=%b tvalid=%b exp=1/1", c, nl_tx_tlast, nl_tx_tvalid); end
            end
            @(posedge aclk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        do_reset();
        rx_tvalid = 4'b1000; tx_tready = 1'b1;
        @(posedge aclk); #1;
        #2;
        checks++; if (grant !== 4'b1000) begin failures++; $display("[TB] FAIL abort_beat1 got=%b exp=1000", grant); end
        @(posedge aclk); #1;
        areset_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0 || rx_tready !== 4'b0) begin failures++; $display("[TB] FAIL abort_immediate grant=%b ready=%b exp=0000/0000", grant, rx_tready); end
        checks++; if (busy !== 1'b0 || tx_tvalid !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy busy=%b tvalid=%b exp=0/0", busy, tx_tvalid); end
        @(negedge aclk);
        areset_n = 1'b1;
        #1;
        checks++; if (grant !== 4'b0) begin failures++; $display("[TB] FAIL abort_early got=%b exp=0000", grant); end
        @(posedge aclk); #1;
        checks++; if (grant !== 4'b1000 || select !== 2'd3) begin failures++; $display("[TB] FAIL abort_regrant grant=%b select=%0d exp=1000/3", grant, select); end
        clear_inputs();
    endtask

    task automatic test_random();
        logic [3:0] exp_grant, exp_ready, n_grant, n_ready;
        logic       exp_tvalid, n_tvalid;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rx_tvalid = 4'($urandom); rx_tlast = 4'($urandom);
            tx_tready = ($urandom_range(0, 3) != 0);
            nl_rx_tvalid = 4'($urandom); nl_rx_tlast = 4'($urandom);
            nl_tx_tready = ($urandom_range(0, 3) != 0);
            #2;
            exp_grant  = m_locked ? (4'b0001 << m_owner) : 4'b0000;
            exp_tvalid = m_locked && rx_tvalid[m_owner];
            exp_ready  = (m_locked && tx_tready) ? (4'b0001 << m_owner) : 4'b0000;
            n_grant    = n_locked ? (4'b0001 << n_owner) : 4'b0000;
            n_tvalid   = n_locked && nl_rx_tvalid[n_owner];
            n_ready    = (n_locked && nl_tx_tready) ? (4'b0001 << n_owner) : 4'b0000;
            checks++; if (grant !== exp_grant) begin failures++; $display("[TB] FAIL rand_grant c=%0d got=%b exp=%b", c, grant, exp_grant); end
            checks++; if (busy !== m_locked) begin failures++; $display("[TB] FAIL rand_busy c=%0d got=%b exp=%b", c, busy, m_locked); end
            checks++; if (select !== 2'(m_select)) begin failures++; $display("[TB] FAIL rand_select c=%0d got=%0d exp=%0d", c, select, m_select); end
            checks++; if (tx_tvalid !== exp_tvalid) begin failures++; $display("[TB] FAIL rand_tvalid c=%0d got=%b exp=%b", c, tx_tvalid, exp_tvalid); end
            checks++; if (rx_tready !== exp_ready) begin failures++; $display("[TB] FAIL rand_ready c=%0d got=%b exp=%b", c, rx_tready, exp_ready); end
            if (m_locked) begin
                checks++; if (tx_tlast !== rx_tlast[m_owner]) begin failures++; $display("[TB] FAIL rand_tlast c=%0d got=%b exp=%b", c, tx_tlast, rx_tlast[m_owner]); end
            end
            checks++; if (nl_grant !== n_grant) begin failures++; $display("[TB] FAIL rand_nl_grant c=%0d got=%b exp=%b", c, nl_grant, n_grant); end
            checks++; if (nl_tx_tvalid !== n_tvalid) begin failures++; $display("[TB] FAIL rand_nl_tvalid c=%0d got=%b exp=%b", c, nl_tx_tvalid, n_tvalid); end
            checks++; if (nl_rx_tready !== n_ready) begin failures++; $display("[TB] FAIL rand_nl_ready c=%0d got=%b exp=%b", c, nl_rx_tready, n_ready); end
            checks++; if (nl_tx_tlast !== 1'b1) begin failures++; $display("[TB] FAIL rand_nl_tlast c=%0d got=%b exp=1", c, nl_tx_tlast); end
            @(posedge aclk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_request();
        test_lock_hold();
        test_backpressure();
        test_no_tlast();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
